// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for the Gray-coded counter family.
// The functions work at MAX_W bits; callers zero-extend narrower values and truncate the result.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_W         = 32;

  function automatic logic [MAX_W-1:0] bin_to_gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extension is harmless here: leading zero Gray bits decode to leading zero binary bits.
  function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: an XOR-prefix chain running from the MSB down.
module gray_to_bin #(
  parameter int WIDTH = gray_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  always_comb begin
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
  end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter that presents its value in both binary and Gray code.
// It supports a load in either code and a one-cycle wrap pulse.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
    .g (load_val),
    .b (load_bin)
  );

  always_comb begin
    next_bin  = bin;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (up) begin
        next_bin  = bin + WIDTH'(1);
        next_wrap = (bin == '1);
      end else begin
        next_bin  = bin - WIDTH'(1);
        next_wrap = (bin == '0);
      end
    end
  end

  // The Gray register is fed from next_bin so that it never trails bin by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= WIDTH'(bin_to_gray(MAX_W'(next_bin)));
      wrap <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed-vector scoreboard bench for gray_counter (WIDTH = 4).
// Expected values are pushed into a queue as stimulus is applied and checked by a separate monitor.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, load_is_gray;
  logic [3:0] load_val;
  logic [3:0] bin, gray, ref_bin;
  logic       wrap;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic       step;
    int         id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vid   = 0;

  localparam logic [3:0] GRAY_TAB [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                           4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                           4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                           4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) dut (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .load_is_gray (load_is_gray), .load_val (load_val),
    .bin (bin), .gray (gray), .wrap (wrap)
  );

  gray_to_bin #(.WIDTH(4)) u_ref (.g (gray), .b (ref_bin));

  task automatic drv(input logic r, e, u, l, lg, input logic [3:0] lv,
                     input logic [3:0] eb, eg, input logic ew, input logic st);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_is_gray = lg; load_val = lv;
    x.bin = eb; x.gray = eg; x.wrap = ew; x.step = st; x.id = vid;
    q.push_back(x);
    vid++;
  endtask

  // Monitor: every cycle is an output; pop one expectation per edge.
  initial begin : monitor
    exp_t       e;
    logic [3:0] prev_gray = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bin !== e.bin) begin
          n_err++;
          $display("FAIL v%0d bin: got %0d want %0d", e.id, bin, e.bin);
        end
        n_cmp++;
        if (gray !== e.gray) begin
          n_err++;
          $display("FAIL v%0d gray: got %b want %b", e.id, gray, e.gray);
        end
        n_cmp++;
        if (wrap !== e.wrap) begin
          n_err++;
          $display("FAIL v%0d wrap: got %b want %b", e.id, wrap, e.wrap);
        end
        n_cmp++;
        if (ref_bin !== e.bin) begin
          n_err++;
          $display("FAIL v%0d gray_decode: got %0d want %0d", e.id, ref_bin, e.bin);
        end
        if (e.step) begin
          n_cmp++;
          if ($countones(gray ^ prev_gray) != 1) begin
            n_err++;
            $display("FAIL v%0d gray_onebit: got %b->%b want one bit changed", e.id, prev_gray, gray);
          end
        end
      end
      prev_gray = gray;
    end
  end

  initial begin : stim
    int wait_cyc;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_is_gray = 1'b0; load_val = 4'd0;

    // Reset for 2 cycles, then count up 16 steps with wrap on the last.
    drv(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'b0000, 0, 0);
    drv(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'b0000, 0, 0);
    for (int i = 1; i <= 16; i++)
      drv(0, 1, 1, 0, 0, 4'd0, 4'(i), GRAY_TAB[i % 16], (i == 16), 1);

    // Count down from 0.
    drv(0, 1, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 1, 1);
    drv(0, 1, 0, 0, 0, 4'd0, 4'd14, 4'b1001, 0, 1);
    drv(0, 0, 0, 0, 0, 4'd0, 4'd14, 4'b1001, 0, 0);

    // Gray and binary loads.
    drv(0, 0, 1, 1, 1, 4'b1101, 4'd9, 4'b1101, 0, 0);
    drv(0, 0, 1, 1, 0, 4'b0110, 4'd6, 4'b0101, 0, 0);

    // Priority: load beats a wrapping count step; rst beats load and en.
    drv(0, 0, 1, 1, 0, 4'b1111, 4'd15, 4'b1000, 0, 0);
    drv(0, 1, 1, 1, 0, 4'b0011, 4'd3, 4'b0010, 0, 0);
    drv(0, 0, 1, 0, 0, 4'd0, 4'd3, 4'b0010, 0, 0);
    drv(1, 1, 1, 1, 0, 4'b0111, 4'd0, 4'b0000, 0, 0);

    // Hold at 10 for 5 cycles.
    drv(0, 0, 1, 1, 0, 4'b1010, 4'd10, 4'b1111, 0, 0);
    for (int i = 0; i < 5; i++)
      drv(0, 0, 1, 0, 0, 4'd0, 4'd10, 4'b1111, 0, 0);

    // Reset mid-count, then resume from 0.
    drv(0, 1, 1, 0, 0, 4'd0, 4'd11, 4'b1110, 0, 1);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd12, 4'b1010, 0, 1);
    drv(1, 1, 1, 0, 0, 4'd0, 4'd0, 4'b0000, 0, 0);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd1, 4'b0001, 0, 1);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd2, 4'b0011, 0, 1);

    // Direction toggle around 5.
    drv(0, 0, 1, 1, 0, 4'd5, 4'd5, 4'b0111, 0, 0);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd6, 4'b0101, 0, 1);
    drv(0, 1, 0, 0, 0, 4'd0, 4'd5, 4'b0111, 0, 1);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd6, 4'b0101, 0, 1);
    drv(0, 1, 0, 0, 0, 4'd0, 4'd5, 4'b0111, 0, 1);

    // Gray load of the top value, then wrap upward.
    drv(0, 1, 0, 1, 1, 4'b1000, 4'd15, 4'b1000, 0, 0);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'b0000, 1, 1);
    drv(0, 1, 1, 0, 0, 4'd0, 4'd1, 4'b0001, 0, 1);

    @(negedge clk);
    en = 1'b0;
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered up/down counter that presents its value in both binary and Gray code. Successor to the fixed 4-bit binary-to-Gray converter: adds a parametrised width, count direction, enable, and a synchronous load accepted in either code. It also flags wrap-around. Used as a standalone lab block and as the pointer source for Gray-coded counters in later Computer Architecture exercises.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_is_gray  input  1  1 = load_val is Gray-coded, 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- bin  output  WIDTH  registered counter value, binary.
- gray  output  WIDTH  registered counter value, Gray (bin ^ (bin >> 1)).
- wrap  output  1  registered one-cycle pulse on modulo wrap.

## Operation
- Priority per rising edge: rst > load > en > hold.
- rst: bin = 0, gray = 0, wrap = 0. This also applies mid-count and when load or en is high.
- load:
  - If load_is_gray = 0: bin = load_val.
  - If load_is_gray = 1: bin = gray_to_bin(load_val), where bit[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i].
  - gray is recomputed from the new bin.
  - wrap = 0.
  - en and up are ignored that cycle.
- en with up = 1: bin = bin + 1, modulo 2^WIDTH.
- en with up = 0: bin = bin − 1, modulo 2^WIDTH.
- wrap = 1 only after a count step that moves bin from 2^WIDTH−1 to 0 (up) or from 0 to 2^WIDTH−1 (down). Otherwise wrap = 0.
- en = 0 and load = 0: bin and gray hold, wrap = 0.
- All arithmetic is unsigned WIDTH-bit; carry and borrow are discarded.
- gray is always consistent with bin in the same cycle; they are never skewed by a cycle.
- Direction may change on any cycle; the step uses the up value sampled at that edge.

## Timing
- All outputs are registered; no combinational path runs from inputs to outputs.
- Latency is 1 cycle: inputs sampled at edge N appear on bin, gray and wrap after edge N.
- wrap is high for exactly the one cycle following the wrapping step. Consecutive wrapping steps (e.g. WIDTH = 2, continuous counting) give separate pulses each time.
- Between successive count steps, gray changes exactly one bit, including across the wrap. Load may change any number of bits.
- Reset values: bin = 0, gray = 0, wrap = 0.

## Structure
- Package gray_pkg:
  - function bin_to_gray(b), returning b ^ (b >> 1).
  - function gray_to_bin(g), the XOR-prefix conversion.
  - constant DEFAULT_WIDTH = 4.
- Sub-module gray_to_bin, parametrised by WIDTH: combinational XOR-prefix chain on the load path, instantiated once. The bench reuses it as a reference model.
- Top level: one WIDTH-bit bin register, one gray register fed by bin_to_gray of next_bin, one wrap flop.

## Test plan
All scenarios use WIDTH = 4.
- Reset and count up: rst for 2 cycles, then en = 1, up = 1 for 16 cycles.
  - During rst: bin = 0, gray = 0000.
  - Step 1: bin = 1, gray = 0001. Step 7: bin = 7, gray = 0100. Step 15: bin = 15, gray = 1000.
  - Step 16: bin = 0, gray = 0000, wrap = 1 for exactly one cycle.
  - Every step changes one gray bit.
- Count down from 0: en = 1, up = 0.
  - bin = 15, gray = 1000, wrap = 1.
  - Next step: bin = 14, gray = 1001, wrap = 0.
- Gray load: load = 1, load_is_gray = 1, load_val = 1101.
  - Next cycle: bin = 9, gray = 1101, wrap = 0.
  - Binary load of 0110 gives bin = 6, gray = 0101.
- Priority:
  - bin = 15, en = 1, up = 1, load = 1, load_val = 0011 (binary): bin = 3, wrap = 0, no wrap pulse.
  - rst = 1 together with load = 1 and en = 1: bin = 0.
- Hold and reset mid-operation:
  - At bin = 10 with en = 0 for 5 cycles: bin stays 10 and gray stays 1111.
  - Then rst for 1 cycle during counting: bin = 0 on the next cycle and counting resumes from 0.
- Direction toggle: at bin = 5, alternate up = 1/0 each cycle with en = 1.
  - bin alternates 6, 5, 6, 5 and gray alternates 0101, 0111.
  - wrap stays 0.
